// File: rtl/sobel_stream_kernel.sv
// sobel_stream_kernel
// Streaming 3x3 Sobel edge engine. Takes a raster-order grayscale stream with
// optional gaps. The 3x3 window is built from two line buffers and three row
// shift registers. For each interior pixel the block outputs either the
// saturated L1 gradient magnitude or a binary threshold decision.
// Latency is fixed: pix_o/valid_o rise three clock edges after the edge that
// accepts the pixel completing the window. The pipeline runs every cycle, so
// gaps in the input show up as gaps of the same length in the output.

module sobel_stream_kernel #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 480,
    parameter int COLS   = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_i,
    input  logic              valid_i,
    input  logic              mode_i,
    input  logic [DATA_W+2:0] thresh_i,
    output logic [DATA_W-1:0] pix_o,
    output logic              valid_o,
    output logic              done_o
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GW = DATA_W + 3;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [GW-1:0] PIX_MAX  = GW'((1 << DATA_W) - 1);

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;
    logic          accept;
    logic          at_origin;

    // Reset takes priority, so no pixel is accepted in a reset cycle.
    assign accept    = valid_i && !rst;
    assign at_origin = (col_reg == '0) && (row_reg == '0);

    // Next raster position: advance on every accepted pixel and wrap at the frame edges.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (rst) begin
            col_next = '0;
            row_next = '0;
        end else if (valid_i) begin
            if (col_reg == COL_LAST) begin
                col_next = '0;
                if (row_reg == ROW_LAST) begin
                    row_next = '0;
                end else begin
                    row_next = row_reg + 1'b1;
                end
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // Register the raster position.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-frame mode and threshold, latched on pixel (0,0)
    // ------------------------------------------------------------------
    logic          mode_reg;
    logic [GW-1:0] thr_reg;

    // Capture the frame's mode and threshold on its first pixel and ignore later changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= 1'b0;
            thr_reg  <= '0;
        end else if (valid_i && at_origin) begin
            mode_reg <= mode_i;
            thr_reg  <= thresh_i;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers
    // ------------------------------------------------------------------
    // lb_rd[0] holds row r-1 and lb_rd[1] holds row r-2 for the current
    // column. The read address is col_next, so the registered read output
    // always belongs to the column about to be accepted. The write goes to
    // col_reg, which differs from col_next whenever a write happens, so
    // read and write never collide.
    logic [DATA_W-1:0] lb_rd    [0:1];
    logic [DATA_W-1:0] lb_wdata [0:1];

    assign lb_wdata[0] = pix_i;
    assign lb_wdata[1] = lb_rd[0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lb
            logic [DATA_W-1:0] mem [0:COLS-1];
            logic [DATA_W-1:0] rd_reg;

            // Line-buffer RAM: write on accept, registered read of the next column.
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_reg] <= lb_wdata[gi];
                end
                rd_reg <= mem[col_next];
            end

            assign lb_rd[gi] = rd_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // 3x3 window shift registers (row 0 = top = oldest row)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] col_in [0:2];
    logic [DATA_W-1:0] win    [0:8];

    assign col_in[0] = lb_rd[1];
    assign col_in[1] = lb_rd[0];
    assign col_in[2] = pix_i;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [DATA_W-1:0] tap_reg [0:2];

            // Shift the new column in from the right on each accepted pixel.
            always_ff @(posedge clk) begin
                if (accept) begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= tap_reg[2];
                    tap_reg[2] <= col_in[gi];
                end
            end

            assign win[gi*3 + 0] = tap_reg[0];
            assign win[gi*3 + 1] = tap_reg[1];
            assign win[gi*3 + 2] = tap_reg[2];
        end
    endgenerate

    // Window qualification. The frame's mode and threshold travel with the
    // window, so a back-to-back frame can recapture them while this frame drains.
    logic          win_v_reg;
    logic          win_done_reg;
    logic          win_mode_reg;
    logic [GW-1:0] win_thr_reg;

    // Flag a complete interior window on the edge that accepts its bottom-right pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_v_reg    <= 1'b0;
            win_done_reg <= 1'b0;
        end else begin
            win_v_reg    <= valid_i && (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
            win_done_reg <= valid_i && (row_reg == ROW_LAST) && (col_reg == COL_LAST);
        end
        if (accept) begin
            win_mode_reg <= mode_reg;
            win_thr_reg  <= thr_reg;
        end
    end

    // ------------------------------------------------------------------
    // S1: registered window
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] s1_d_reg [0:8];
    logic              s1_v_reg;
    logic              s1_done_reg;
    logic              s1_mode_reg;
    logic [GW-1:0]     s1_thr_reg;

    // Snapshot the window and its side-band into stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg    <= 1'b0;
            s1_done_reg <= 1'b0;
        end else begin
            s1_v_reg    <= win_v_reg;
            s1_done_reg <= win_done_reg;
        end
        for (int k = 0; k < 9; k++) begin
            s1_d_reg[k] <= win[k];
        end
        s1_mode_reg <= win_mode_reg;
        s1_thr_reg  <= win_thr_reg;
    end

    // ------------------------------------------------------------------
    // S2: signed gradients
    // ------------------------------------------------------------------
    function automatic logic [GW-1:0] widen(input logic [DATA_W-1:0] x);
        return GW'(x);
    endfunction

    logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GW-1:0] gx_next, gy_next;

    // Each side sums to at most 4*(2^DATA_W-1), so GW bits hold the signed difference.
    assign gx_pos  = widen(s1_d_reg[2]) + (widen(s1_d_reg[5]) << 1) + widen(s1_d_reg[8]);
    assign gx_neg  = widen(s1_d_reg[0]) + (widen(s1_d_reg[3]) << 1) + widen(s1_d_reg[6]);
    assign gy_pos  = widen(s1_d_reg[6]) + (widen(s1_d_reg[7]) << 1) + widen(s1_d_reg[8]);
    assign gy_neg  = widen(s1_d_reg[0]) + (widen(s1_d_reg[1]) << 1) + widen(s1_d_reg[2]);
    assign gx_next = $signed(gx_pos - gx_neg);
    assign gy_next = $signed(gy_pos - gy_neg);

    logic signed [GW-1:0] gx_reg, gy_reg;
    logic                 s2_v_reg;
    logic                 s2_done_reg;
    logic                 s2_mode_reg;
    logic [GW-1:0]        s2_thr_reg;

    // Register the gradients and the side-band into stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_reg    <= 1'b0;
            s2_done_reg <= 1'b0;
        end else begin
            s2_v_reg    <= s1_v_reg;
            s2_done_reg <= s1_done_reg;
        end
        gx_reg      <= gx_next;
        gy_reg      <= gy_next;
        s2_mode_reg <= s1_mode_reg;
        s2_thr_reg  <= s1_thr_reg;
    end

    // ------------------------------------------------------------------
    // S3: magnitude, saturation / threshold, output registers
    // ------------------------------------------------------------------
    logic [GW-1:0]     abs_x, abs_y, mag;
    logic [DATA_W-1:0] pix_value;

    // |Gx|+|Gy| is at most 8*(2^DATA_W-1), which still fits in GW bits.
    assign abs_x = gx_reg[GW-1] ? $unsigned(-gx_reg) : $unsigned(gx_reg);
    assign abs_y = gy_reg[GW-1] ? $unsigned(-gy_reg) : $unsigned(gy_reg);
    assign mag   = abs_x + abs_y;

    // Select the saturated magnitude or the threshold decision.
    always_comb begin
        pix_value = '0;
        if (s2_mode_reg) begin
            pix_value = (mag >= s2_thr_reg) ? '1 : '0;
        end else if (mag > PIX_MAX) begin
            pix_value = '1;
        end else begin
            pix_value = mag[DATA_W-1:0];
        end
    end

    // Output stage: pix_o keeps its last value while no result is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_o   <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= s2_v_reg;
            done_o  <= s2_v_reg && s2_done_reg;
            if (s2_v_reg) begin
                pix_o <= pix_value;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_kernel.sv
// tb_sobel_stream_kernel
// Scoreboard bench for a 5x6 frame. Each qualifying input pushes its expected
// pixel, its done flag and its accept-edge index. Each valid_o pops one entry
// and compares pixel, done and latency.

module tb_sobel_stream_kernel;

    localparam int DW = 8;
    localparam int R  = 5;
    localparam int C  = 6;
    localparam int NP = R * C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pix_i = '0;
    logic          valid_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [DW+2:0] thresh_i = '0;
    logic [DW-1:0] pix_o;
    logic          valid_o;
    logic          done_o;

    always #5 clk = ~clk;

    sobel_stream_kernel #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .pix_i    (pix_i),
        .valid_i  (valid_i),
        .mode_i   (mode_i),
        .thresh_i (thresh_i),
        .pix_o    (pix_o),
        .valid_o  (valid_o),
        .done_o   (done_o)
    );

    typedef struct {
        int pix;
        int done;
        int edge_n;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  edge_n = 0;
    int  nout = 0;
    int  ndone = 0;
    int  hold_ref = 0;
    int  tb_row = 0;
    int  tb_col = 0;
    int  tb_mode = 0;
    int  tb_thr = 0;
    int  img[R][C];
    int  src[R][C];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference Sobel on the stored frame, for the window whose bottom-right pixel is (r,c).
    function automatic int sobel_ref(input int r, input int c);
        int gx, gy, mag;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (tb_mode != 0) return (mag >= tb_thr) ? 255 : 0;
        return (mag > 255) ? 255 : mag;
    endfunction

    task automatic monitor();
        sb_t e;
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("pix", int'(pix_o), e.pix);
                check_val("done", int'(done_o), e.done);
                check_val("latency", edge_n - e.edge_n, 3);
                $display("out pix=%0d exp=%0d done=%0d lat=%0d", pix_o, e.pix, done_o, edge_n - e.edge_n);
            end
            hold_ref = int'(pix_o);
            nout++;
            if (done_o) ndone++;
        end else begin
            check_val("hold", int'(pix_o), hold_ref);
            check_val("done_idle", int'(done_o), 0);
        end
    endtask

    task automatic tick(input logic v, input int p);
        valid_i = v;
        pix_i   = p[DW-1:0];
        if (v) begin
            if (tb_row == 0 && tb_col == 0) begin
                tb_mode = int'(mode_i);
                tb_thr  = int'(thresh_i);
            end
            img[tb_row][tb_col] = p;
            if (tb_row >= 2 && tb_col >= 2) begin
                sb_q.push_back('{sobel_ref(tb_row, tb_col),
                                 (tb_row == R-1 && tb_col == C-1) ? 1 : 0,
                                 edge_n + 1});
            end
            if (tb_col == C-1) begin
                tb_col = 0;
                tb_row = (tb_row == R-1) ? 0 : tb_row + 1;
            end else begin
                tb_col++;
            end
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        tb_row   = 0;
        tb_col   = 0;
        hold_ref = 0;
        check_val("rst_pix", int'(pix_o), 0);
        check_val("rst_valid", int'(valid_o), 0);
        check_val("rst_done", int'(done_o), 0);
    endtask

    task automatic send_frame(input int gap, input int npix, input int m, input int t,
                              input int flip_at, input int flip_m);
        int tt;
        tt       = t;
        mode_i   = m[0];
        thresh_i = tt[DW+2:0];
        for (int i = 0; i < npix; i++) begin
            if (i == flip_at) begin
                tt       = t ^ 341;
                mode_i   = flip_m[0];
                thresh_i = tt[DW+2:0];
            end
            tick(1'b1, src[i / C][i % C]);
            for (int g = 0; g < gap; g++) tick(1'b0, int'($urandom_range(0, 255)));
        end
    endtask

    task automatic end_test(input string name, input int exp_out, input int exp_done);
        for (int i = 0; i < 6; i++) tick(1'b0, 0);
        check_val({name, "_leftover"}, sb_q.size(), 0);
        check_val({name, "_outputs"}, nout, exp_out);
        check_val({name, "_done_pulses"}, ndone, exp_done);
        nout  = 0;
        ndone = 0;
    endtask

    task automatic fill_src(input int kind);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                case (kind)
                    0:       src[r][c] = 100;
                    1:       src[r][c] = (c >= 3) ? 255 : 0;
                    2:       src[r][c] = 10 * c;
                    default: src[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    initial begin
        do_reset();

        // 1: flat frame, magnitude mode
        fill_src(0);
        send_frame(0, NP, 0, 0, -1, 0);
        end_test("flat", 12, 1);

        // 2: vertical step, magnitude saturates at the edge columns
        fill_src(1);
        send_frame(0, NP, 0, 0, -1, 0);
        end_test("step", 12, 1);

        // 3: ramp in threshold mode, on and just above the magnitude of 80
        fill_src(2);
        send_frame(0, NP, 1, 80, -1, 0);
        end_test("ramp_t80", 12, 1);
        send_frame(0, NP, 1, 81, -1, 0);
        end_test("ramp_t81", 12, 1);

        // 4: random frame continuous, then the same frame with two idle cycles per pixel
        fill_src(3);
        send_frame(0, NP, 0, 0, -1, 0);
        end_test("rand_cont", 12, 1);
        send_frame(2, NP, 0, 0, -1, 0);
        end_test("rand_gap", 12, 1);

        // 5: reset after 17 pixels, then a full frame
        fill_src(3);
        send_frame(0, 17, 0, 0, -1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 0);
        check_val("partial_outputs", nout, 0);
        send_frame(0, NP, 0, 0, -1, 0);
        end_test("after_rst", 12, 1);

        // 6: back-to-back frames, mode flipped mid-frame 1 and captured by frame 2
        fill_src(3);
        send_frame(0, NP, 0, 0, 10, 1);
        send_frame(0, NP, 1, 200, 15, 0);
        end_test("b2b", 24, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
